zc_period_phase_meter: RTL and testbench
========================================

# zc_period_phase_meter

Measures a sampled 14-bit sinusoid from the ADC path. Rising zero crossings are detected with hysteresis. Clock periods are accumulated over 2^AVG_LOG2 input cycles, and the lag from the DDS zero-crossing pulse to each input crossing is reported. It sits on the receive side of the DDS sine/cosine generator: the DDS drives the excitation and its `pulso` is the phase reference; this block closes the loop on the returning signal.

## Interface
- `DATA_WIDTH`, 14, sample width (signed two's complement)
- `CNT_WIDTH`, 32, width of period and lag counters/outputs
- `AVG_LOG2`, 4, log2 of input periods accumulated per measurement (0..8)

- `clk` in 1: system clock; one clock domain only
- `reset` in 1: synchronous, active-high reset
- `clken` in 1: `adc_i` valid this cycle
- `adc_i` in DATA_WIDTH: signed ADC sample
- `hyst_i` in DATA_WIDTH-1: unsigned hysteresis threshold H
- `ref_pulso_i` in 1: DDS rising-zero-crossing pulse, one cycle wide
- `period_o` out CNT_WIDTH: clocks spanned by the last 2^AVG_LOG2 input periods
- `out_valid` out 1: one-cycle strobe, `period_o` updated
- `lag_o` out CNT_WIDTH: clocks from last `ref_pulso_i` to last input crossing
- `lag_valid` out 1: one-cycle strobe, `lag_o` updated
- `pulso` out 1: one-cycle strobe per detected input rising crossing
- `lost_o` out 1: measurement timed out; sticky until next `out_valid`

## Operation
- Comparator state `pos`:
  - Set when `clken` and adc_i >= +H.
  - Cleared when `clken` and adc_i <= −H.
  - Otherwise held. With `clken` low, the sample is ignored.
- Comparison is signed and sign-extended to DATA_WIDTH+1 bits. H=0 means a plain sign test, with 0 treated as positive.
- Crossing event `xing`: `pos` transitions 0→1. `pulso` is registered from `xing`.
- FSM states:
  - `IDLE`: wait for `xing`. On `xing`: cnt←0, nper←0, go to `MEASURE`.
  - `MEASURE`: cnt increments every clk, independent of `clken`. On `xing`:
    - nper←nper+1.
    - If nper+1 == 2^AVG_LOG2: `period_o`←cnt+1, `out_valid`=1, `lost_o`←0, cnt←0, nper←0, stay in `MEASURE`.
    - Otherwise cnt continues.
    - Timeout: if cnt == 2^CNT_WIDTH−1 with no completing `xing`, `lost_o`←1 and go to `IDLE`.
- Lag path, independent of the FSM:
  - `ref_pulso_i` high: lag_cnt←0, `armed`←1. Otherwise lag_cnt increments, saturating at all-ones.
  - On `xing` with `armed`: `lag_o`←lag_cnt value for this cycle (0 if `ref_pulso_i` is high in the same cycle), `lag_valid`=1.
  - An `xing` while not armed produces no `lag_valid`.
  - `armed` stays set; each new `ref_pulso_i` re-zeros lag_cnt.
- Reset values: `pos`=0, FSM=`IDLE`, all counters 0, `armed`=0, all outputs 0.

## Timing
- Sample presented with `clken` at edge k → `pos` and `pulso` update at edge k, so `pulso` is high in cycle k..k+1.
- `out_valid` and `lag_valid` coincide with the `pulso` of the causing crossing. Latency is 1 clk from the sampling edge.
- Crossings at edges e0 (start) … eN (N=2^AVG_LOG2) give `period_o` = eN − e0 exactly.
- Back-to-back measurements are gapless: eN is e0 of the next measurement.
- `ref_pulso_i` and `xing` in the same cycle give `lag_o`=0.
- Reset asserted mid-`MEASURE`: the next edge forces `IDLE` and zeros outputs. The partial accumulation is discarded. The first crossing after reset only starts a measurement.
- The `MEASURE` timeout check has priority below `xing`. An `xing` on the saturating cycle completes normally.

## Structure
- Package `meter_pkg`:
  - `meter_state_t` enum {IDLE, MEASURE}.
  - Default localparams for DATA_WIDTH, CNT_WIDTH, AVG_LOG2.
- Sub-module `zc_hyst_detector`:
  - Inputs: `clk`, `reset`, `clken`, `adc_i`, `hyst_i`.
  - Outputs: `pos` and the registered `pulso`.
  - Reused later for quadrature zero-crossing.
- Top module holds the FSM, period counter, lag counter, and output registers.

## Test plan
- Reset, then 20 idle clocks with `adc_i`=0 and H=100 → all outputs 0, no `pulso`.
- Square wave ±4000 with 100-clk period, H=100, AVG_LOG2=2 → `out_valid` every 400 clks with `period_o`=400; `pulso` every 100 clks.
- Same stimulus with `ref_pulso_i` 25 clks before each input crossing → `lag_valid` at each crossing, `lag_o`=25; with `ref_pulso_i` coincident → `lag_o`=0.
- Ramp oscillating −80..+80 with H=100 and `clken`=1 → no `pulso`, FSM stays `IDLE`. Then the signal crosses ±150 → `pulso` on the first ≥100 sample only.
- CNT_WIDTH=8: one crossing, then a constant positive input → `lost_o`=1 after 255 clks in `MEASURE`, FSM `IDLE`. The next completed measurement clears `lost_o`.
- Assert `reset` 1 cycle after the 2nd of 4 crossings → outputs 0. The next valid `period_o` equals exactly 4 periods counted from the first post-reset crossing.

Source files
------------

// File: rtl/zc_period_phase_meter_pkg.sv
// ============================================================================
// meter_pkg : shared state type and default sizes for the zero-crossing meter
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

package meter_pkg;

    localparam int DEF_DATA_WIDTH = 14;
    localparam int DEF_CNT_WIDTH  = 32;
    localparam int DEF_AVG_LOG2   = 4;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } meter_state_t;

endpackage

`default_nettype wire

// File: rtl/zc_hyst_detector.sv
// ============================================================================
// zc_hyst_detector : hysteresis comparator with registered rising-crossing pulse
// Revision         : 1.0 - initial release
// ============================================================================
`default_nettype none

module zc_hyst_detector
    import meter_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clken,
    input  logic signed [DATA_WIDTH-1:0] adc_i,
    input  logic        [DATA_WIDTH-2:0] hyst_i,
    output logic                         pos,
    output logic                         pos_next,
    output logic                         pulso
);

    logic signed [DATA_WIDTH:0] sample_ext;
    logic signed [DATA_WIDTH:0] thr_hi;
    logic signed [DATA_WIDTH:0] thr_lo;
    logic                       set_c;
    logic                       clr_c;
    logic                       xing;

    // One extra bit so that -H never overflows for any H.
    assign sample_ext = {adc_i[DATA_WIDTH-1], adc_i};
    assign thr_hi     = {2'b00, hyst_i};
    assign thr_lo     = -thr_hi;

    // Set wins over clear so that a zero sample reads as positive when H=0.
    assign set_c    = clken && (sample_ext >= thr_hi);
    assign clr_c    = clken && (sample_ext <= thr_lo);
    assign pos_next = set_c ? 1'b1 : (clr_c ? 1'b0 : pos);
    assign xing     = pos_next & ~pos;

    always_ff @(posedge clk) begin
        if (reset) begin
            pos   <= 1'b0;
            pulso <= 1'b0;
        end else begin
            pos   <= pos_next;
            pulso <= xing;
        end
    end

endmodule

`default_nettype wire

// File: rtl/zc_period_phase_meter.sv
// ============================================================================
// zc_period_phase_meter : averaged period and DDS-referenced lag of a sampled sine
// Revision              : 1.0 - initial release
// ============================================================================
`default_nettype none

module zc_period_phase_meter
    import meter_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
    parameter int AVG_LOG2   = DEF_AVG_LOG2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clken,
    input  logic signed [DATA_WIDTH-1:0] adc_i,
    input  logic        [DATA_WIDTH-2:0] hyst_i,
    input  logic                         ref_pulso_i,
    output logic        [CNT_WIDTH-1:0]  period_o,
    output logic                         out_valid,
    output logic        [CNT_WIDTH-1:0]  lag_o,
    output logic                         lag_valid,
    output logic                         pulso,
    output logic                         lost_o
);

    localparam int                    NPER_W    = AVG_LOG2 + 1;
    localparam logic [NPER_W-1:0]     NPER_LAST = NPER_W'((1 << AVG_LOG2) - 1);
    localparam logic [NPER_W-1:0]     NPER_ONE  = NPER_W'(1);
    localparam logic [CNT_WIDTH-1:0]  CNT_MAX   = '1;
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = CNT_WIDTH'(1);

    logic                 pos;
    logic                 pos_next;
    logic                 xing;

    meter_state_t         state;
    meter_state_t         state_next;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] cnt_next;
    logic [NPER_W-1:0]    nper;
    logic [NPER_W-1:0]    nper_next;
    logic [CNT_WIDTH-1:0] period_next;
    logic                 out_valid_next;
    logic                 lost_next;

    logic [CNT_WIDTH-1:0] lag_cnt;
    logic [CNT_WIDTH-1:0] lag_cnt_next;
    logic                 armed;
    logic                 armed_next;

    zc_hyst_detector #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_det (
        .clk      (clk),
        .reset    (reset),
        .clken    (clken),
        .adc_i    (adc_i),
        .hyst_i   (hyst_i),
        .pos      (pos),
        .pos_next (pos_next),
        .pulso    (pulso)
    );

    assign xing = pos_next & ~pos;

    // ------------------------------------------------------------------
    // Period measurement FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_next     = state;
        cnt_next       = cnt;
        nper_next      = nper;
        period_next    = period_o;
        out_valid_next = 1'b0;
        lost_next      = lost_o;
        case (state)
            IDLE: begin
                if (xing) begin
                    state_next = MEASURE;
                    cnt_next   = '0;
                    nper_next  = '0;
                end
            end
            MEASURE: begin
                cnt_next = cnt + CNT_ONE;
                // The closing crossing counts its own clock, hence cnt+1.
                if (xing && (nper == NPER_LAST)) begin
                    period_next    = cnt + CNT_ONE;
                    out_valid_next = 1'b1;
                    lost_next      = 1'b0;
                    cnt_next       = '0;
                    nper_next      = '0;
                end else begin
                    if (xing) begin
                        nper_next = nper + NPER_ONE;
                    end
                    if (cnt == CNT_MAX) begin
                        lost_next  = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            nper      <= '0;
            period_o  <= '0;
            out_valid <= 1'b0;
            lost_o    <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            nper      <= nper_next;
            period_o  <= period_next;
            out_valid <= out_valid_next;
            lost_o    <= lost_next;
        end
    end

    // ------------------------------------------------------------------
    // Lag from DDS reference pulse to input crossing
    // ------------------------------------------------------------------
    assign lag_cnt_next = ref_pulso_i        ? '0 :
                          (lag_cnt == CNT_MAX) ? CNT_MAX : lag_cnt + CNT_ONE;
    assign armed_next   = armed | ref_pulso_i;

    always_ff @(posedge clk) begin
        if (reset) begin
            lag_cnt   <= '0;
            armed     <= 1'b0;
            lag_o     <= '0;
            lag_valid <= 1'b0;
        end else begin
            lag_cnt   <= lag_cnt_next;
            armed     <= armed_next;
            lag_valid <= xing & armed_next;
            if (xing && armed_next) begin
                lag_o <= lag_cnt_next;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_zc_period_phase_meter.sv
// ============================================================================
// tb_zc_period_phase_meter : randomized bench with timestamp-based reference model
// Revision                 : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_zc_period_phase_meter;

    logic               clk = 1'b0;
    logic               reset;
    logic               clken;
    logic signed [13:0] adc;
    logic        [12:0] hyst;
    logic               ref_p;

    logic [31:0] period32, lag32;
    logic        ov32, lv32, pulso32, lost32;
    logic [7:0]  period8, lag8;
    logic        ov8, lv8, pulso8, lost8;

    always #5 clk = ~clk;

    zc_period_phase_meter #(.DATA_WIDTH(14), .CNT_WIDTH(32), .AVG_LOG2(2)) dut (
        .clk(clk), .reset(reset), .clken(clken), .adc_i(adc), .hyst_i(hyst),
        .ref_pulso_i(ref_p), .period_o(period32), .out_valid(ov32), .lag_o(lag32),
        .lag_valid(lv32), .pulso(pulso32), .lost_o(lost32)
    );

    zc_period_phase_meter #(.DATA_WIDTH(14), .CNT_WIDTH(8), .AVG_LOG2(2)) dut8 (
        .clk(clk), .reset(reset), .clken(clken), .adc_i(adc), .hyst_i(hyst),
        .ref_pulso_i(ref_p), .period_o(period8), .out_valid(ov8), .lag_o(lag8),
        .lag_valid(lv8), .pulso(pulso8), .lost_o(lost8)
    );

    int     total = 0;
    int     bad   = 0;
    int     phase = 0;
    int     npulso = 0;
    int     nov = 0;
    longint t = 0;

    // Reference model: crossing timestamps rather than counters.
    localparam int NPER = 4;
    longint span [2] = '{64'd4294967296, 64'd256};
    bit     m_pos, m_pulso, m_armed;
    longint m_ref_t;
    bit     m_meas [2], m_lost [2], m_ov [2], m_lv [2];
    longint m_start [2], m_period [2], m_lag [2];
    int     m_n [2];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, t);
        end
    endtask

    task automatic model_step();
        bit set_c, clr_c, xing;
        int a, h;
        t++;
        if (reset) begin
            m_pos = 0; m_pulso = 0; m_armed = 0;
            for (int k = 0; k < 2; k++) begin
                m_meas[k] = 0; m_lost[k] = 0; m_ov[k] = 0; m_lv[k] = 0;
                m_period[k] = 0; m_lag[k] = 0; m_n[k] = 0;
            end
        end else begin
            a = int'(adc);
            h = int'(hyst);
            set_c = clken && (a >= h);
            clr_c = clken && (a <= -h);
            xing  = set_c && !m_pos;
            if (set_c) m_pos = 1;
            else if (clr_c) m_pos = 0;
            m_pulso = xing;
            if (ref_p) begin
                m_ref_t = t;
                m_armed = 1;
            end
            for (int k = 0; k < 2; k++) begin
                m_lv[k] = xing && m_armed;
                if (m_lv[k])
                    m_lag[k] = ((t - m_ref_t) > span[k] - 1) ? span[k] - 1 : (t - m_ref_t);
                m_ov[k] = 0;
                if (m_meas[k]) begin
                    if (xing) begin
                        m_n[k]++;
                        if (m_n[k] == NPER) begin
                            m_period[k] = (t - m_start[k]) % span[k];
                            m_ov[k] = 1; m_lost[k] = 0; m_start[k] = t; m_n[k] = 0;
                        end
                    end
                    if (!m_ov[k] && (t - m_start[k]) == span[k]) begin
                        m_lost[k] = 1;
                        m_meas[k] = 0;
                    end
                end else if (xing) begin
                    m_meas[k] = 1; m_start[k] = t; m_n[k] = 0;
                end
            end
        end
    endtask

    task automatic cmp();
        chk("pulso32", pulso32, m_pulso);
        chk("out_valid32", ov32, m_ov[0]);
        chk("period32", period32, m_period[0]);
        chk("lost32", lost32, m_lost[0]);
        chk("lag_valid32", lv32, m_lv[0]);
        chk("lag32", lag32, m_lag[0]);
        chk("pulso8", pulso8, m_pulso);
        chk("out_valid8", ov8, m_ov[1]);
        chk("period8", period8, m_period[1]);
        chk("lost8", lost8, m_lost[1]);
        chk("lag_valid8", lv8, m_lv[1]);
        chk("lag8", lag8, m_lag[1]);
        if (pulso32) npulso++;
        if (ov32) nov++;
        if ((phase >= 1) && (phase <= 3) && ov32) chk("period_400", period32, 400);
        if ((phase == 2) && lv32) chk("lag_25", lag32, 25);
        if ((phase == 3) && lv32) chk("lag_0", lag32, 0);
        if ((phase == 6) && ov32) chk("post_reset_period32", period32, 200);
        if ((phase == 6) && ov8) chk("post_reset_period8", period8, 200);
    endtask

    task automatic apply(input int a, input bit r, input bit ce, input bit rs);
        @(negedge clk);
        if (t > 0) cmp();
        adc   = a[13:0];
        ref_p = r;
        clken = ce;
        reset = rs;
        model_step();
    endtask

    function automatic int sqv(input int i, input int p, input int amp);
        return ((i % p) < (p / 2)) ? -amp : amp;
    endfunction

    initial begin
        int base;
        reset = 1'b1; clken = 1'b0; adc = '0; hyst = 13'd100; ref_p = 1'b0;

        // Reset and idle
        for (int i = 0; i < 3; i++) apply(0, 0, 1, 1);
        for (int i = 0; i < 20; i++) apply(0, 0, 1, 0);
        chk("idle_reset_period", period32, 0);
        chk("idle_no_pulso", npulso, 0);

        // Square wave, 100-clk period, with/without DDS reference
        for (int ph = 1; ph <= 3; ph++) begin
            phase = ph;
            base  = npulso;
            for (int i = 0; i < 600; i++) begin
                int v;
                v = sqv(i, 100, 4000 + int'($urandom_range(400)) - 200);
                apply(v, (ph == 2) ? ((i % 100) == 25) : (ph == 3) ? ((i % 100) == 50) : 1'b0, 1, 0);
            end
            chk("square_pulso_count", npulso - base, 6);
        end

        // Sub-threshold ramp, then a swing through the thresholds
        phase = 4;
        apply(0, 0, 1, 1);
        apply(0, 0, 1, 1);
        base = npulso;
        for (int c = 0; c < 5; c++)
            for (int j = 0; j < 40; j++)
                apply((j < 20) ? (-80 + 8 * j) : (80 - 8 * (j - 20)), 0, 1, 0);
        apply(-80, 0, 1, 0);
        chk("ramp_no_pulso", npulso - base, 0);
        chk("ramp_no_period", ov32, 0);
        base = npulso;
        for (int c = 0; c < 4; c++)
            for (int j = 0; j < 60; j++)
                apply((j < 30) ? (-150 + 10 * j) : (150 - 10 * (j - 30)), 0, 1, 0);
        apply(-150, 0, 1, 0);
        chk("tri150_pulso_count", npulso - base, 4);

        // Timeout on the 8-bit counter, then recovery
        phase = 5;
        apply(0, 0, 1, 1);
        for (int i = 0; i < 10; i++) apply(-2000, 0, 1, 0);
        for (int i = 0; i < 300; i++) apply(2000, 0, 1, 0);
        chk("timeout_lost8", lost8, 1);
        chk("no_timeout_lost32", lost32, 0);
        for (int i = 0; i < 320; i++) apply(sqv(i, 40, 3000), 0, 1, 0);
        chk("lost8_cleared", lost8, 0);

        // Reset one cycle after the second crossing
        apply(-3000, 0, 1, 1);
        apply(-3000, 0, 1, 1);
        phase = 6;
        nov   = 0;
        for (int p = 0; p < 8; p++)
            for (int i = 0; i < 50; i++) begin
                int v;
                v = (i >= 25) ? 3000 : -3000;
                if ((p == 1) && (i > 26)) v = -3000;
                apply(v, 0, 1, (p == 1) && (i == 26));
            end
        chk("post_reset_ov_count", nov, 1);

        // Randomized segments
        phase = 7;
        for (int seg = 0; seg < 6; seg++) begin
            int h, p, amp, rp;
            h   = int'($urandom_range(600));
            p   = int'($urandom_range(120, 20));
            amp = int'($urandom_range(6000, h + 300));
            rp  = (seg % 2 == 1) ? 400 : 30;
            hyst = h[12:0];
            for (int i = 0; i < p * 6; i++) begin
                int  v;
                bit  ce;
                ce = ($urandom_range(9) != 0);
                v  = sqv(i, p, amp) + int'($urandom_range(200)) - 100;
                if (!ce) v = int'($urandom_range(16000)) - 8000;
                apply(v, $urandom_range(rp - 1) == 0, ce, 0);
            end
        end
        hyst = '0;
        for (int i = 0; i < 300; i++)
            apply(int'($urandom_range(2)) - 1, $urandom_range(19) == 0, $urandom_range(3) != 0, 0);

        apply(0, 0, 1, 0);
        apply(0, 0, 1, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
